// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: display prefetch owns every PPW-th slot, the CPU FSM uses the rest.
// Display words land in pix_data two cycles after issue; CPU writes ack at T+1, reads at T+2.
module vram_arbiter #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int H_TOTAL  = 800,
  parameter int V_TOTAL  = 525,
  parameter int PPW_LOG2 = 2,
  parameter int ADDR_W   = 17,
  parameter int DATA_W   = 16
) (
  input  logic              pixel_clk,
  input  logic              rst,
  input  logic [10:0]       hcounter,
  input  logic [10:0]       vcounter,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic [ADDR_W-1:0] vram_addr,
  output logic              vram_we,
  output logic [DATA_W-1:0] vram_wdata,
  input  logic [DATA_W-1:0] vram_rdata,
  output logic [DATA_W-1:0] pix_data,
  output logic              pix_load
);

  localparam int          PPW         = 1 << PPW_LOG2;
  localparam int          STAGES      = 1;
  localparam logic [10:0] H_FETCH_END = 11'(H_ACTIVE - PPW);
  localparam logic [10:0] H_WRAP      = 11'(H_TOTAL - PPW);
  localparam logic [10:0] V_ACT       = 11'(V_ACTIVE);
  localparam logic [10:0] V_ACT_M1    = 11'(V_ACTIVE - 1);
  localparam logic [10:0] V_LAST      = 11'(V_TOTAL - 1);

  typedef enum logic [1:0] {IDLE, WACK, RWAIT, RDONE} state_t;

  state_t              state, state_nx;
  logic [ADDR_W-1:0]   disp_addr, fetch_addr, cpu_addr_q;
  logic                slot_phase, frame_start, disp_slot, cpu_issue;
  logic [STAGES:0]     vld_pipe;

  // Fetches run one word ahead; the last slot of a line prefetches word 0 of the next.
  assign slot_phase  = (hcounter[PPW_LOG2-1:0] == '0);
  assign frame_start = (hcounter == H_WRAP) && (vcounter == V_LAST);
  assign disp_slot   = !rst && slot_phase &&
                       (((hcounter < H_FETCH_END) && (vcounter < V_ACT)) ||
                        ((hcounter == H_WRAP) && ((vcounter == V_LAST) || (vcounter < V_ACT_M1))));
  assign fetch_addr  = frame_start ? '0 : disp_addr;
  assign cpu_issue   = !rst && (state == IDLE) && cpu_req && !disp_slot;
  assign vram_wdata  = cpu_wdata;
  assign pix_load    = vld_pipe[STAGES];

  always_ff @(posedge pixel_clk) begin
    if (rst) begin
      disp_addr  <= '0;
      cpu_addr_q <= '0;
      vld_pipe   <= '0;
      pix_data   <= '0;
      cpu_rdata  <= '0;
    end else begin
      if (disp_slot) disp_addr <= fetch_addr + ADDR_W'(1);
      if (cpu_issue) cpu_addr_q <= cpu_addr;
      vld_pipe <= {vld_pipe[STAGES-1:0], disp_slot};
      if (vld_pipe[STAGES-1]) pix_data <= vram_rdata;
      if (state == RWAIT) cpu_rdata <= vram_rdata;
    end
  end

  always_ff @(posedge pixel_clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Every non-IDLE state, including the ack cycle, ignores cpu_req.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (cpu_issue) state_nx = cpu_we ? WACK : RWAIT;
      WACK:    state_nx = IDLE;
      RWAIT:   state_nx = RDONE;
      RDONE:   state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    vram_addr = cpu_addr_q;
    vram_we   = 1'b0;
    cpu_ack   = (state == WACK) || (state == RDONE);
    if (rst) begin
      vram_addr = '0;
    end else if (disp_slot) begin
      vram_addr = fetch_addr;
    end else if (cpu_issue) begin
      vram_addr = cpu_addr;
      vram_we   = cpu_we;
    end
  end

endmodule

// File: tb/tb_vram_arbiter.sv
// Randomized bench for vram_arbiter: a transaction-level CPU model and a raster-position
// display model predict every bus cycle, ack, read value and pixel load.
module tb_vram_arbiter;
  localparam int ADDR_W = 17;
  localparam int DATA_W = 16;

  logic              pixel_clk = 1'b0;
  logic              rst;
  logic [10:0]       hcounter, vcounter;
  logic              cpu_req, cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata, cpu_rdata, vram_wdata, vram_rdata, pix_data;
  logic              cpu_ack, vram_we, pix_load;
  logic [ADDR_W-1:0] vram_addr;

  always #5 pixel_clk = ~pixel_clk;

  vram_arbiter dut (
    .pixel_clk(pixel_clk), .rst(rst), .hcounter(hcounter), .vcounter(vcounter),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata), .vram_addr(vram_addr), .vram_we(vram_we),
    .vram_wdata(vram_wdata), .vram_rdata(vram_rdata), .pix_data(pix_data), .pix_load(pix_load)
  );

  function automatic logic [15:0] init_val(int a);
    return (a == 5) ? 16'hA5A5 : 16'((a * 7) ^ 16'h5A5A);
  endfunction

  // Synchronous single-port VRAM; unwritten words read back as init_val.
  logic [15:0] vmem [0:131071];
  bit          vwr  [0:131071];
  always @(posedge pixel_clk) begin
    if (vram_we) begin
      vmem[int'(vram_addr)] <= vram_wdata;
      vwr[int'(vram_addr)]  <= 1'b1;
    end
    vram_rdata <= vwr[int'(vram_addr)] ? vmem[int'(vram_addr)] : init_val(int'(vram_addr));
  end

  logic [15:0] ref_mem [int];
  function automatic logic [15:0] ref_rd(int a);
    return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
  endfunction

  // Word fetched at (h,v) is the one covering pixel h+4 of the raster, if that pixel is visible.
  function automatic int fetch_of(int h, int v);
    int p, l;
    if (h % 4 != 0) return -1;
    p = h + 4;
    l = v;
    if (p >= 800) begin
      p = p - 800;
      l = (v + 1) % 525;
    end
    return (p < 640 && l < 480) ? l * 160 + p / 4 : -1;
  endfunction

  typedef struct {int c; logic [15:0] v;} load_t;
  load_t       loads[$];
  int          cyc, n_chk, n_pass, gap, issue_c, ack_c, p_addr, t4_addr;
  bit          pend, p_we, rnd_en, t4_on;
  logic [15:0] p_data, p_rval, pix_exp, rdata_exp;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cyc %0d v=%0d h=%0d)",
                  tag, got, exp, cyc, vcounter, hcounter);
  endtask

  task automatic start_req(bit we, int addr, logic [15:0] data);
    cpu_req = 1'b1; cpu_we = we; cpu_addr = ADDR_W'(addr); cpu_wdata = data;
    pend = 1'b1; p_we = we; p_addr = addr; p_data = data;
    issue_c = cyc + ((fetch_of(int'(hcounter), int'(vcounter)) >= 0) ? 1 : 0);
    ack_c   = issue_c + (we ? 1 : 2);
  endtask

  task automatic check_cycle();
    int  h, v, fa;
    bit  exp_we, exp_ack, exp_ld;
    h = int'(hcounter);
    v = int'(vcounter);
    fa = rst ? -1 : fetch_of(h, v);
    exp_we = 1'b0; exp_ack = 1'b0; exp_ld = 1'b0;
    if (rst) chk("rst_addr", 32'(vram_addr), 32'd0);
    else if (fa >= 0) begin
      chk("disp_addr", 32'(vram_addr), 32'(fa));
      loads.push_back('{cyc + 2, ref_rd(fa)});
    end
    if (pend && !rst && cyc == issue_c) begin
      chk("cpu_addr", 32'(vram_addr), 32'(p_addr));
      exp_we = p_we;
      if (p_we) begin
        chk("cpu_wdata", 32'(vram_wdata), 32'(p_data));
        ref_mem[p_addr] = p_data;
      end else p_rval = ref_rd(p_addr);
    end
    if (pend && cyc == ack_c) begin
      exp_ack = 1'b1;
      if (!p_we) rdata_exp = p_rval;
    end
    chk("vram_we", 32'(vram_we), 32'(exp_we));
    chk("cpu_ack", 32'(cpu_ack), 32'(exp_ack));
    chk("cpu_rdata", 32'(cpu_rdata), 32'(rdata_exp));
    if (loads.size() > 0 && loads[0].c == cyc) begin
      exp_ld  = 1'b1;
      pix_exp = loads[0].v;
      void'(loads.pop_front());
    end
    chk("pix_load", 32'(pix_load), 32'(exp_ld));
    chk("pix_data", 32'(pix_data), 32'(pix_exp));
    // Raster landmarks at the frame boundary and the collision case on line 10.
    if (!rst) begin
      if (v == 524 && h == 796) chk("fs_addr", 32'(vram_addr), 32'd0);
      if (v == 524 && h == 798) chk("fs_pix_load", 32'(pix_load), 32'd1);
      if (v == 0 && h == 0)     chk("l0_w1_addr", 32'(vram_addr), 32'd1);
      if (v == 0 && h == 632)   chk("l0_w159_addr", 32'(vram_addr), 32'd159);
      if (v == 0 && h == 796)   chk("l1_w0_addr", 32'(vram_addr), 32'd160);
      if (t4_on && v == 10 && h == 8)  chk("t4_disp_addr", 32'(vram_addr), 32'd1603);
      if (t4_on && v == 10 && h == 9) begin
        chk("t4_cpu_we", 32'(vram_we), 32'd1);
        chk("t4_cpu_addr", 32'(vram_addr), 32'(t4_addr));
      end
      if (t4_on && v == 10 && h == 10) chk("t4_ack", 32'(cpu_ack), 32'd1);
    end
    if (rst) begin
      pend = 1'b0;
      loads.delete();
      pix_exp   = '0;
      rdata_exp = '0;
    end
  endtask

  task automatic drive();
    int a;
    if (pend && cyc > ack_c) pend = 1'b0;
    if (!pend) cpu_req = 1'b0;
    if (!pend && rnd_en) begin
      if (vcounter == 11'd10 && hcounter == 11'd8) begin
        t4_addr = 100000 + int'($urandom_range(0, 999));
        start_req(1'b1, t4_addr, 16'($urandom));
        t4_on = 1'b1;
      end else if (gap > 0) gap--;
      else if (!(vcounter == 11'd10 && hcounter < 11'd8)) begin
        a = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 131071))
                                        : int'($urandom_range(0, 4095));
        start_req(1'($urandom), a, 16'($urandom));
        gap = int'($urandom_range(0, 3));
      end
    end
  endtask

  task automatic tick();
    @(negedge pixel_clk);
    check_cycle();
    @(posedge pixel_clk);
    #1;
    cyc++;
    if (hcounter == 11'd799) begin
      hcounter = '0;
      vcounter = (vcounter == 11'd524) ? 11'd0 : vcounter + 11'd1;
    end else hcounter = hcounter + 11'd1;
    drive();
  endtask

  task automatic drain();
    rnd_en = 1'b0;
    while (pend) tick();
  endtask

  initial begin
    rst = 1'b1; cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 17'h1F; cpu_wdata = 16'hFFFF;
    hcounter = '0; vcounter = 11'd500;
    cyc = 0; n_chk = 0; n_pass = 0; gap = 0; pend = 1'b0; rnd_en = 1'b0; t4_on = 1'b0;
    pix_exp = '0; rdata_exp = '0; p_rval = '0; issue_c = 0; ack_c = 0;
    @(posedge pixel_clk);
    #1;
    cyc = 1;
    tick();
    rst = 1'b0;

    // Write then read back in vertical blanking, then a held-request read of a preset word.
    vcounter = 11'd490; hcounter = '0;
    start_req(1'b1, 'h1234, 16'hBEEF);
    while (pend) tick();
    start_req(1'b0, 'h1234, 16'h0);
    while (pend) tick();
    chk("t3_rdata", 32'(cpu_rdata), 32'h0000BEEF);
    start_req(1'b0, 5, 16'h0);
    while (pend) tick();
    chk("t5_rdata", 32'(cpu_rdata), 32'h0000A5A5);
    repeat (4) tick();

    rnd_en = 1'b1;
    repeat (200) tick();
    drain();

    // Contiguous raster across a frame start into the first visible lines.
    vcounter = 11'd523; hcounter = '0;
    rnd_en = 1'b1;
    repeat (14 * 800) tick();
    drain();

    // Reset while a read sits in its data-capture cycle.
    vcounter = 11'd500; hcounter = '0;
    start_req(1'b0, 100, 16'h0);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    repeat (3) tick();
    start_req(1'b0, 7, 16'h0);
    while (pend) tick();
    chk("t6_rdata", 32'(cpu_rdata), 32'(ref_rd(7)));

    vcounter = 11'd524; hcounter = 11'd700;
    rnd_en = 1'b1;
    repeat (1800) tick();
    drain();
    repeat (3) tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
